fetch_unit: RTL and testbench

//  Instruction-fetch stage of the single-issue RISC-V core. Sits directly upstream of the

---
 rtl/fetch_unit.sv | 73 +++++++
 tb/tb_fetch_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address and
// holds the fetched word in the IF/ID register behind a valid/ready handshake.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        misalign_o
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc_out;
    logic        r_valid;
    logic        r_misalign;

    logic        w_run;
    logic        w_load;
    logic        w_aligned;

    assign w_run     = (r_state == ST_RUN);
    assign w_aligned = (redirect_pc_i[1:0] == 2'b00);
    // Refill only when the IF/ID slot is empty or being drained this edge.
    assign w_load    = w_run && !redirect_i && (!r_valid || ready_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC;
            r_instr    <= NOP_INSTR;
            r_pc_out   <= '0;
            r_valid    <= 1'b0;
            r_misalign <= 1'b0;
        end else if (w_run && redirect_i) begin
            r_valid <= 1'b0;
            if (w_aligned) begin
                r_pc <= redirect_pc_i;
            end else begin
                r_misalign <= 1'b1;
                r_state    <= ST_HALT;
            end
        end else if (w_load) begin
            r_instr  <= imem_rdata_i;
            r_pc_out <= r_pc;
            r_valid  <= 1'b1;
            r_pc     <= r_pc + 32'd4;
        end else if (r_valid && ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign imem_addr_o = r_pc;
    assign instr_o     = r_instr;
    assign pc_o        = r_pc_out;
    assign valid_o     = r_valid;
    assign misalign_o  = r_misalign;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected transfers are queued by the stimulus and
// popped by a monitor whenever decode accepts an instruction.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        misalign;

    logic        rst2_n;
    logic [31:0] addr2;
    logic [31:0] rdata2;
    logic [31:0] instr2;
    logic [31:0] pc2;
    logic        valid2;
    logic        misalign2;

    int unsigned n_cmp;
    int unsigned n_bad;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } xfer_t;
    xfer_t exp_q[$];

    // imem word n holds 0x1000_0000 + n; 1K-word memory, upper bits alias
    assign rdata  = 32'h1000_0000 + {22'd0, addr[11:2]};
    assign rdata2 = 32'h1000_0000 + {22'd0, addr2[11:2]};

    fetch_unit u_dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .imem_addr_o   (addr),
        .imem_rdata_i  (rdata),
        .redirect_i    (redir),
        .redirect_pc_i (rpc),
        .instr_o       (instr),
        .pc_o          (pc),
        .valid_o       (valid),
        .ready_i       (ready),
        .misalign_o    (misalign)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk_i         (clk),
        .rst_ni        (rst2_n),
        .imem_addr_o   (addr2),
        .imem_rdata_i  (rdata2),
        .redirect_i    (1'b0),
        .redirect_pc_i (32'h0000_0000),
        .instr_o       (instr2),
        .pc_o          (pc2),
        .valid_o       (valid2),
        .ready_i       (1'b1),
        .misalign_o    (misalign2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] p);
        xfer_t x;
        x.pc    = p;
        x.instr = 32'h1000_0000 + {22'd0, p[11:2]};
        exp_q.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Inputs change 1 ns after posedge, so at negedge they are what the next edge sees.
    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL xfer_unexpected: got pc %08h expected no transfer", pc);
            end else begin
                xfer_t x;
                x = exp_q.pop_front();
                check("xfer_pc", pc, x.pc);
                check("xfer_instr", instr, x.instr);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        rst_n  = 1'b1;
        rst2_n = 1'b1;
        ready  = 1'b1;
        redir  = 1'b0;
        rpc    = '0;
        #1;
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        step();
        step();
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_pc", pc, 32'd0);
        check("rst_misalign", {31'd0, misalign}, 32'd0);
        check("rst_addr", addr, 32'd0);
        check("rst_addr_wrap", addr2, 32'hFFFF_FFFC);

        // streaming from reset
        push(32'd0);
        push(32'd4);
        push(32'd8);
        rst_n = 1'b1;
        step();
        check("first_valid", {31'd0, valid}, 32'd1);
        check("first_pc", pc, 32'd0);
        step();
        step();
        check("stream_pc8", pc, 32'd8);

        // stall at pc 8
        ready = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            step();
            check("stall_pc", pc, 32'd8);
            check("stall_instr", instr, 32'h1000_0002);
            check("stall_addr", addr, 32'h0000_000C);
            check("stall_valid", {31'd0, valid}, 32'd1);
        end
        ready = 1'b1;
        step();
        check("after_stall_pc", pc, 32'h0000_000C);

        // aligned redirect while decode stalled flushes pc 0xC
        ready = 1'b0;
        redir = 1'b1;
        rpc   = 32'h0000_0100;
        step();
        check("redir_valid", {31'd0, valid}, 32'd0);
        check("redir_addr", addr, 32'h0000_0100);
        check("redir_pc_hold", pc, 32'h0000_000C);
        redir = 1'b0;
        ready = 1'b1;
        push(32'h0000_0100);
        step();
        check("target_valid", {31'd0, valid}, 32'd1);
        check("target_pc", pc, 32'h0000_0100);
        step();
        check("target_next_pc", pc, 32'h0000_0104);

        // misaligned redirect halts fetch
        redir = 1'b1;
        rpc   = 32'h0000_0102;
        ready = 1'b0;
        step();
        check("mis_flag", {31'd0, misalign}, 32'd1);
        check("mis_valid", {31'd0, valid}, 32'd0);
        check("mis_addr", addr, 32'h0000_0108);
        rpc   = 32'h0000_0200;
        ready = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            step();
            check("halt_valid", {31'd0, valid}, 32'd0);
            check("halt_flag", {31'd0, misalign}, 32'd1);
            check("halt_addr", addr, 32'h0000_0108);
        end

        // reset clears the halt, then drop reset mid-cycle while streaming
        rst_n = 1'b0;
        redir = 1'b0;
        #1;
        check("halt_rst_flag", {31'd0, misalign}, 32'd0);
        check("halt_rst_addr", addr, 32'd0);
        step();
        push(32'd0);
        push(32'd4);
        push(32'd8);
        rst_n = 1'b1;
        repeat (4) step();
        check("pre_drop_pc", pc, 32'h0000_000C);
        #2;
        rst_n = 1'b0;
        #1;
        check("drop_valid", {31'd0, valid}, 32'd0);
        check("drop_instr", instr, 32'h0000_0013);
        check("drop_addr", addr, 32'd0);
        check("drop_pc", pc, 32'd0);
        step();
        push(32'd0);
        push(32'd4);
        rst_n = 1'b1;
        step();
        check("restart_pc", pc, 32'd0);
        step();
        step();
        ready = 1'b0;
        check("restart_pc8", pc, 32'd8);

        // PC wraps modulo 2^32
        rst2_n = 1'b1;
        step();
        check("wrap_pc0", pc2, 32'hFFFF_FFFC);
        check("wrap_instr0", instr2, 32'h1000_03FF);
        check("wrap_valid0", {31'd0, valid2}, 32'd1);
        step();
        check("wrap_pc1", pc2, 32'd0);
        check("wrap_instr1", instr2, 32'h1000_0000);

        step();
        check("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
